// File: rtl/alu4_pkg.sv
// Shared opcode constants for the 4-bit registered ALU.
package alu4_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu4_core.sv
// Combinational ALU datapath: result plus carry/borrow/shift-out and overflow flags.
module alu4_core
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] res,
    output logic             c,
    output logic             v
);

    // One extra bit catches the carry (ADD) or borrow (SUB) out of the MSB.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Select result and flags; flags default to 0 for the logic ops.
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (sel)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff[WIDTH-1:0];
                c   = diff[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: begin
                res = {a[WIDTH-2:0], 1'b0};
                c   = a[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, a[WIDTH-1:1]};
                c   = a[0];
            end
            default: begin
                res = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu4.sv
// Registered ALU: one result per cycle, latency 1, synchronous active-high reset.
module alu4
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             c,
    output logic             z,
    output logic             v
);

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic [WIDTH-1:0] out_q;
    logic             c_q;
    logic             v_q;

    alu4_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a  (a),
        .b  (b),
        .sel(sel),
        .res(res),
        .c  (res_c),
        .v  (res_v)
    );

    // Output registers; reset wins over the in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            out_q <= res;
            c_q   <= res_c;
            v_q   <= res_v;
        end
    end

    assign out = out_q;
    assign c   = c_q;
    assign v   = v_q;
    // Zero flag follows the registered result, so it reads 1 after reset.
    assign z   = (out_q == '0);

endmodule

// File: tb/tb_alu4.sv
// Self-checking bench for alu4: directed vectors plus randomized stimulus
// against an integer-arithmetic reference model.
module tb_alu4;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] out;
    logic       c;
    logic       z;
    logic       v;

    int n_checks = 0;
    int n_errors = 0;

    // Expected registered outputs for the most recent edge.
    int  exp_out;
    int  exp_c;
    int  exp_z;
    int  exp_v;
    bit  have_exp = 1'b0;

    alu4 #(
        .WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .sel(sel),
        .out(out),
        .c  (c),
        .z  (z),
        .v  (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (a=%0d b=%0d sel=%0d rst=%0b)",
                     tag, got, exp, a, b, sel, rst);
        end
    endtask

    function automatic int to_signed4(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Reference model written from the arithmetic definition of each op.
    function automatic void model(input int ia, input int ib, input int is,
                                  output int o, output int oc, output int ov);
        int s;
        int r;
        o  = 0;
        oc = 0;
        ov = 0;
        case (is)
            0: begin
                s  = ia + ib;
                o  = s % 16;
                oc = (s >= 16) ? 1 : 0;
                r  = to_signed4(ia) + to_signed4(ib);
                ov = (r > 7 || r < -8) ? 1 : 0;
            end
            1: begin
                s  = ia - ib;
                o  = (s + 16) % 16;
                oc = (ia < ib) ? 1 : 0;
                r  = to_signed4(ia) - to_signed4(ib);
                ov = (r > 7 || r < -8) ? 1 : 0;
            end
            2: o = ia & ib;
            3: o = ia | ib;
            4: o = ia ^ ib;
            5: o = 15 - ia;
            6: begin
                o  = (ia * 2) % 16;
                oc = ia / 8;
            end
            default: begin
                o  = ia / 2;
                oc = ia % 2;
            end
        endcase
    endfunction

    // Drive one cycle of inputs, confirm outputs hold until the edge,
    // then confirm the new result one edge later.
    task automatic step(input string tag, input int ta, input int tb, input int ts,
                        input bit tr);
        int o;
        int oc;
        int ov;
        a   = 4'(ta);
        b   = 4'(tb);
        sel = 3'(ts);
        rst = tr;
        #1;
        if (have_exp) begin
            check({tag, "_hold_out"}, 32'(out), 32'(exp_out));
            check({tag, "_hold_c"}, 32'(c), 32'(exp_c));
        end
        if (tr) begin
            o  = 0;
            oc = 0;
            ov = 0;
        end else begin
            model(ta, tb, ts, o, oc, ov);
        end
        @(posedge clk);
        #1;
        exp_out  = o;
        exp_c    = oc;
        exp_v    = ov;
        exp_z    = (o == 0) ? 1 : 0;
        have_exp = 1'b1;
        check({tag, "_out"}, 32'(out), 32'(exp_out));
        check({tag, "_c"}, 32'(c), 32'(exp_c));
        check({tag, "_z"}, 32'(z), 32'(exp_z));
        check({tag, "_v"}, 32'(v), 32'(exp_v));
    endtask

    initial begin
        a   = '0;
        b   = '0;
        sel = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Reset state.
        step("rst_init", 9, 3, 0, 1'b1);
        check("rst_init_z_const", 32'(z), 32'd1);

        // Sweep of all opcodes with a=0010, b=1111 (sel changes every cycle).
        for (int s = 0; s < 8; s++) step($sformatf("sweep%0d", s), 2, 15, s, 1'b0);
        // Spot-check a few sweep results against literal values.
        step("sweep_add_lit", 2, 15, 0, 1'b0);
        check("sweep_add_lit_out", 32'(out), 32'd1);
        step("sweep_sub_lit", 2, 15, 1, 1'b0);
        check("sweep_sub_lit_out", 32'(out), 32'd3);
        check("sweep_sub_lit_c", 32'(c), 32'd1);

        // Signed overflow.
        step("ovf_add", 7, 1, 0, 1'b0);
        check("ovf_add_lit_v", 32'(v), 32'd1);
        step("ovf_sub", 8, 1, 1, 1'b0);
        check("ovf_sub_lit_out", 32'(out), 32'd7);

        // Zero results.
        step("zero_sub", 5, 5, 1, 1'b0);
        step("zero_and", 10, 5, 2, 1'b0);

        // Shift-out.
        step("shl_out", 9, 0, 6, 1'b0);
        step("shr_out", 9, 0, 7, 1'b0);

        // Reset mid-stream discards the ADD, then release computes it.
        step("pre_rst", 15, 1, 0, 1'b0);
        step("mid_rst", 15, 1, 0, 1'b1);
        step("rel_rst", 15, 1, 0, 1'b0);
        check("rel_rst_lit_c", 32'(c), 32'd1);

        // Reset held high for several edges with varying inputs.
        for (int i = 0; i < 3; i++) step("rst_hold", 13 - i, 6 + i, i + 3, 1'b1);

        // Randomized stimulus with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu4.md
ALU4 -- requirements
Module: alu4

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the data width of a, b and out; all requirements below are stated for WIDTH=4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port a, input, WIDTH bits: operand A, unsigned or two's-complement depending on op.
REQ-005 SHALL have port b, input, WIDTH bits: operand B.
REQ-006 SHALL have port sel, input, 3 bits: operation select.
REQ-007 SHALL have port out, output, WIDTH bits: registered result.
REQ-008 SHALL have port c, output, 1 bit: registered carry/borrow/shift-out flag.
REQ-009 SHALL have port z, output, 1 bit: registered zero flag.
REQ-010 SHALL have port v, output, 1 bit: registered signed-overflow flag.

Function
REQ-011 SHALL sample a, b and sel on each rising clk edge and present out, c, z and v from that edge (latency 1 cycle, one new result every cycle, no handshake).
REQ-012 SHALL decode sel as 000 ADD (a+b), 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 SHL (a<<1, LSB 0), 111 SHR (a>>1 logical, MSB 0).
REQ-013 SHALL compute ADD/SUB modulo 2^WIDTH, with out equal to the low WIDTH bits.
REQ-014 SHALL set c to the carry out of bit WIDTH-1 for ADD.
REQ-015 SHALL set c to the borrow for SUB, i.e. 1 exactly when unsigned a < b.
REQ-016 SHALL set c to a[WIDTH-1] for SHL and to a[0] for SHR.
REQ-017 SHALL clear c to 0 for AND, OR, XOR and NOT.
REQ-018 SHALL set v for ADD when a and b have the same sign and out's sign differs.
REQ-019 SHALL set v for SUB when a and b have different signs and out's sign differs from a's sign.
REQ-020 SHALL clear v to 0 for all other ops.
REQ-021 SHALL set z to 1 exactly when the registered out equals 0, for every op.
REQ-022 SHALL be fully specified for all 8 sel codes, with no latches and no X propagation from a defined input.

Reset
REQ-023 SHALL, when rst is high at a rising edge, load out=0, c=0 and v=0, and z=1 (consistent with out=0), regardless of a, b and sel.
REQ-024 SHALL give rst priority over computation; a reset asserted mid-stream discards the in-flight operation, and the first result after deassertion is from the inputs sampled on the first edge with rst low.
REQ-025 SHALL leave outputs at their post-reset values while rst is held high.

Structure
REQ-026 SHALL place the sel opcode constants (OP_ADD..OP_SHR) in shared package alu4_pkg.
REQ-027 SHALL use one combinational sub-module, alu4_core, computing the result and the c/v flags, with alu4 adding the output registers and z.

Verification
REQ-028 SHALL check a=0010, b=1111 swept over sel 0..7, each result one cycle later: ADD out=0001 c=1 v=0 z=0; SUB out=0011 c=1 v=0; AND 0010; OR 1111; XOR 1101; NOT 1101; SHL 0100 c=0; SHR 0001 c=0.
REQ-029 SHALL check overflow: a=0111, b=0001, ADD -> out=1000, c=0, v=1; a=1000, b=0001, SUB -> out=0111, c=0, v=1.
REQ-030 SHALL check zero: a=0101, b=0101, SUB -> out=0000, z=1, c=0, v=0; a=1010, b=0101, AND -> out=0000, z=1.
REQ-031 SHALL check reset: drive ADD with a=1111, b=0001, assert rst for one edge -> out=0000, c=0, z=1, v=0; release -> next edge out=0000, c=1, z=1.
REQ-032 SHALL check shift-out: a=1001, SHL -> out=0010, c=1; SHR -> out=0100, c=1.
REQ-033 SHALL check latency by changing sel every cycle and confirming each result appears exactly one edge after its inputs.
